// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter in front of a shared ALU: grant, issue for one cycle, hold response.
// Define ALU_ARB_FIXED_PRIO_EN to make port 0 always win ties (no last_grant state).
module alu_share_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_ctrl,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_ctrl,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_flag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_flag
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  typedef struct packed {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } op_t;

  state_e          state_q, state_d;
  op_t             op_q, op_d, op_sel;
  logic            rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_flag_q, rsp_flag_d;
  logic            grant_vld, grant_id;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_id = ~req0_valid;
  end
`else
  logic last_grant_q, last_grant_d;

  // On a tie, favour the port that did not win last time.
  always_comb begin
    grant_id     = (req0_valid & req1_valid) ? ~last_grant_q : ~req0_valid;
    last_grant_d = grant_vld ? grant_id : last_grant_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    grant_vld = (state_q == IDLE) & (req0_valid | req1_valid);
    op_sel    = grant_id ? op_t'{req1_ctrl, req1_a, req1_b}
                         : op_t'{req0_ctrl, req0_a, req0_b};
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flag_d   = rsp_flag_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          op_d       = op_sel;
          rsp_id_d   = grant_id;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        rsp_result_d = alu_result;
        // Only branch compares (1010..1111) carry a meaningful flag.
        rsp_flag_d   = alu_flag & op_q.ctrl[3] & (op_q.ctrl[2] | op_q.ctrl[1]);
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flag_q   <= rsp_flag_d;
    end
  end

  // rsp_valid decodes straight from the state flop so reset drops it without a clock.
  assign rsp_valid  = (state_q == RESP);
  assign alu_ctrl   = op_q.ctrl;
  assign alu_a      = op_q.a;
  assign alu_b      = op_q.b;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flag   = rsp_flag_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a small behavioural ALU.
module tb_alu_share_arbiter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]      req0_ctrl, req1_ctrl, alu_ctrl;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
  logic            alu_flag, rsp_valid, rsp_ready, rsp_id, rsp_flag;
  logic [XLEN-1:0] rsp_result;
  logic            force_flag;
  logic            cmp_flag;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag)
  );

  // Behavioural ALU; force_flag lets a test drive the flag high regardless of the op.
  always_comb begin
    alu_result = '0;
    cmp_flag   = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a ^ alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_a & alu_b;
      4'b0101: alu_result = alu_a << alu_b[4:0];
      4'b0110: alu_result = alu_a >> alu_b[4:0];
      4'b0111: alu_result = $signed(alu_a) >>> alu_b[4:0];
      4'b1000: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b1001: alu_result = {31'd0, alu_a < alu_b};
      4'b1010: cmp_flag = (alu_a == alu_b);
      4'b1011: cmp_flag = (alu_a != alu_b);
      4'b1100: cmp_flag = ($signed(alu_a) < $signed(alu_b));
      4'b1101: cmp_flag = ($signed(alu_a) >= $signed(alu_b));
      4'b1110: cmp_flag = (alu_a < alu_b);
      default: cmp_flag = (alu_a >= alu_b);
    endcase
    alu_flag = cmp_flag | force_flag;
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0; force_flag = 0;
    req0_ctrl = '0; req0_a = '0; req0_b = '0;
    req1_ctrl = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called just after a negedge with inputs set; returns 1ns after the negedge of the grant cycle.
  task automatic wait_grant(output int id, output int waited, output bit ok);
    ok = 0; id = -1; waited = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        id = req1_ready ? 1 : 0;
        ok = 1;
        break;
      end
      waited++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0; force_flag = 0;
    req0_ctrl = '0; req0_a = '0; req0_b = '0;
    req1_ctrl = '0; req1_a = '0; req1_b = '0;
    @(negedge clk);
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_flag, req0_ready, req1_ready} !== 5'b0 ||
        alu_ctrl !== 4'd0 || alu_a !== '0 || alu_b !== '0 || rsp_result !== '0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b id=%b flag=%b rdy=%b%b ctrl=%h a=%h b=%h res=%h, want all 0",
               rsp_valid, rsp_id, rsp_flag, req0_ready, req1_ready, alu_ctrl, alu_a, alu_b, rsp_result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int id, w; bit ok;
    apply_reset();
    req0_valid = 1; req0_ctrl = 4'b0000; req0_a = 5; req0_b = 7;
    wait_grant(id, w, ok);
    n_chk++;
    if (!ok || id != 0 || w != 0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: ok=%0d id=%0d waited=%0d, want id 0 immediately", ok, id, w);
    end
    @(negedge clk); req0_valid = 0;
    n_chk++;
    if (alu_ctrl !== 4'b0000 || alu_a !== 32'd5 || alu_b !== 32'd7 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_issue: ctrl=%h a=%0d b=%0d valid=%b, want 0/5/7/0", alu_ctrl, alu_a, alu_b, rsp_valid);
    end
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_id !== 1'b0 || rsp_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp: valid=%b res=%0d id=%b flag=%b, want 1/12/0/0", rsp_valid, rsp_result, rsp_id, rsp_flag);
    end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int id, w; bit ok;
    int exp_id [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_id = '{0, 0, 0, 0};
`else
    exp_id = '{0, 1, 0, 1};
`endif
    apply_reset();
    req0_valid = 1; req0_ctrl = 4'b0000; req0_a = 1; req0_b = 1;
    req1_valid = 1; req1_ctrl = 4'b0001; req1_a = 9; req1_b = 4;
    rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(id, w, ok);
      n_chk++;
      if (!ok || id != exp_id[k] || (k > 0 && w != 0) || (req0_ready & req1_ready)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: ok=%0d id=%0d waited=%0d, want id %0d", k, ok, id, w, exp_id[k]);
      end
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id[k][0] ||
          rsp_result !== ((exp_id[k] == 0) ? 32'd2 : 32'd5)) begin
        n_fail++;
        $display("FAIL rr_rsp%0d: valid=%b id=%b res=%0d, want id %0d", k, rsp_valid, rsp_id, rsp_result, exp_id[k]);
      end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
  endtask

  task automatic test_branch_flag();
    int id, w; bit ok;
    apply_reset();
    req1_valid = 1; req1_ctrl = 4'b1100; req1_a = 32'hFFFF_FFFF; req1_b = 1; force_flag = 1;
    wait_grant(id, w, ok);
    n_chk++;
    if (!ok || id != 1) begin
      n_fail++;
      $display("FAIL blt_grant: ok=%0d id=%0d, want 1", ok, id);
    end
    @(negedge clk); req1_valid = 0;
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_flag !== 1'b1 || rsp_id !== 1'b1) begin
      n_fail++;
      $display("FAIL blt_rsp: valid=%b flag=%b id=%b, want 1/1/1", rsp_valid, rsp_flag, rsp_id);
    end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
    req1_valid = 1; req1_ctrl = 4'b1001;
    wait_grant(id, w, ok);
    @(negedge clk); req1_valid = 0;
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_flag !== 1'b0 || rsp_result !== 32'd0 || rsp_id !== 1'b1) begin
      n_fail++;
      $display("FAIL sltu_rsp: valid=%b flag=%b res=%0d id=%b, want 1/0/0/1", rsp_valid, rsp_flag, rsp_result, rsp_id);
    end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0; force_flag = 0;
  endtask

  task automatic test_stall();
    int id, w; bit ok;
    logic [XLEN-1:0] snap_res;
    logic            snap_id, snap_flag;
    int              exp_next;
    apply_reset();
    req0_valid = 1; req0_ctrl = 4'b0010; req0_a = 32'hF0F0_0000; req0_b = 32'h0FF0_1234;
    req1_valid = 1; req1_ctrl = 4'b1010; req1_a = 3; req1_b = 3;
    wait_grant(id, w, ok);
    @(negedge clk);
    @(negedge clk);
    snap_res = rsp_result; snap_id = rsp_id; snap_flag = rsp_flag;
    n_chk++;
    if (rsp_valid !== 1'b1 || snap_res !== 32'hFF00_1234 || snap_id !== 1'b0 || snap_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_first: valid=%b res=%h id=%b flag=%b, want 1/ff001234/0/0", rsp_valid, snap_res, snap_id, snap_flag);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'hFF00_1234 || rsp_id !== 1'b0 || rsp_flag !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b res=%h id=%b flag=%b rdy=%b%b", k, rsp_valid, rsp_result, rsp_id, rsp_flag, req0_ready, req1_ready);
      end
    end
    @(negedge clk);
    rsp_ready = 1; #1;
    n_chk++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_same_cycle: rdy=%b%b, want 00", req0_ready, req1_ready);
    end
    @(negedge clk); rsp_ready = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_next = 0;
`else
    exp_next = 1;
`endif
    wait_grant(id, w, ok);
    n_chk++;
    if (!ok || w != 0 || id != exp_next) begin
      n_fail++;
      $display("FAIL stall_next_grant: ok=%0d id=%0d waited=%0d, want id %0d waited 0", ok, id, w, exp_next);
    end
    @(negedge clk); req0_valid = 0; req1_valid = 0;
    @(negedge clk); rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
  endtask

  task automatic test_reset_mid();
    int id, w; bit ok;
    apply_reset();
    req0_valid = 1; req0_ctrl = 4'b0000; req0_a = 5; req0_b = 7; rsp_ready = 1;
    wait_grant(id, w, ok);
    @(negedge clk); req0_valid = 0;
    n_chk++;
    if (alu_a !== 32'd5) begin
      n_fail++;
      $display("FAIL mid_issue: alu_a=%0d, want 5", alu_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_flag, req0_ready, req1_ready} !== 5'b0 ||
        alu_ctrl !== 4'd0 || alu_a !== '0 || alu_b !== '0 || rsp_result !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: valid=%b a=%0d b=%0d res=%0d rdy=%b%b, want all 0",
               rsp_valid, alu_a, alu_b, rsp_result, req0_ready, req1_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b0 || rsp_result !== '0) begin
        n_fail++;
        $display("FAIL mid_no_rsp%0d: valid=%b res=%0d, want 0/0", k, rsp_valid, rsp_result);
      end
    end
    rsp_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_branch_flag();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
